alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 32, giving operand and result width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports reqK_valid, input, 1 and reqK_ready, output, 1 (K=0,1): request handshake.
REQ-005 The block SHALL have ports reqK_op, input, 4 (ALU opcode 1..13); reqK_a and reqK_b, input, W (operands).
REQ-006 The block SHALL have ports rspK_valid, output, 1 and rspK_ready, input, 1 (K=0,1): response handshake.
REQ-007 The block SHALL have ports rsp_res, output, W; rsp_carry, output, 1; rsp_z, output, 1: shared response payload.
REQ-008 The block SHALL have ports alu_I, output, 4; alu_EX, output, 1; alu_op1 and alu_op2, output, W: drive to the registered ALU.
REQ-009 The block SHALL have ports alu_res, input, W; alu_carry, input, 1; alu_z, input, 1: registered ALU outputs.
REQ-010 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-012 In IDLE, reqK_ready SHALL be high only for the granted requester; both low in ISSUE and RESP.
REQ-013 Arbitration SHALL be round-robin: one valid requester is granted; if both valid, the requester not granted last time wins.
REQ-014 Grant SHALL depend only on current reqK_valid and the last-grant register, never on reqK_ready.
REQ-015 On reqK_valid && reqK_ready at an edge: opcode and operands SHALL be captured into holding registers, owner recorded, last-grant updated to K, state -> ISSUE.
REQ-016 In ISSUE (exactly one cycle): alu_EX=1, alu_I/alu_op1/alu_op2 from holding registers; state -> RESP at next edge.
REQ-017 alu_EX SHALL be 0 in every state except ISSUE; alu_I/op1/op2 SHALL hold last captured values outside ISSUE.
REQ-018 In RESP: rspK_valid=1 for owner only; rsp_res/rsp_carry/rsp_z SHALL be alu_res/alu_carry/alu_z passed through.
REQ-019 rspK_valid SHALL stay high, payload stable, until rspK_ready is high at an edge; then state -> IDLE.
REQ-020 Response latency SHALL be exactly 2 cycles from the accepting edge to first cycle of rspK_valid; peak throughput one op per 3 cycles.
REQ-021 rspK_ready of the non-owner SHALL be ignored; rsp payload outside RESP SHALL equal alu inputs (don't-care to consumers).
REQ-022 Opcodes 0, 14, 15 SHALL be forwarded unchanged (ALU yields 0, z=1); no error signalling.
REQ-023 A request deasserted while not granted SHALL be dropped without side effects; a new request arriving during ISSUE/RESP SHALL wait in IDLE.
REQ-024 Back-to-back: a request accepted in the IDLE cycle directly following RESP completion SHALL follow REQ-015..020 unchanged.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, alu_EX=0, rsp0_valid=rsp1_valid=0, busy=0, holding registers=0, last-grant=1 (req0 wins first tie).
REQ-026 Reset mid-operation SHALL discard the pending op; no response SHALL be issued for it after release.
REQ-027 In the first cycle after rst_n rises, reqK_ready SHALL follow REQ-012/013 normally.

Verification
REQ-028 Single op: req0 ADD a=0xFFFFFFFF b=1, rsp0_ready=1 -> alu_EX high one cycle; rsp0_valid 2 cycles after accept, rsp_res=0, rsp_carry=1, rsp_z=1.
REQ-029 Tie: req0 and req1 valid continuously after reset -> grants req0,req1,req0,req1; each response routed to correct rspK_valid only.
REQ-030 Backpressure: req1 SLT a=3 b=5, rsp1_ready low 4 cycles -> rsp1_valid held, rsp_res=1 stable, busy=1, req0_ready=0 throughout; IDLE after ready.
REQ-031 Reset mid-op: rst_n low during ISSUE -> rspK_valid and alu_EX 0 immediately; after release no stale response; next req0 granted.
REQ-032 Illegal opcode 15 with a=7 b=9 -> op issued, rsp_res=0, rsp_z=1; FSM returns to IDLE normally.
REQ-033 Misrouted ready: owner req0 in RESP, rsp1_ready=1, rsp0_ready=0 -> state stays RESP, rsp0_valid remains 1.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a registered ALU
module alu_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp_res,
    output logic         rsp_carry,
    output logic         rsp_z,
    output logic [3:0]   alu_I,
    output logic         alu_EX,
    output logic [W-1:0] alu_op1,
    output logic [W-1:0] alu_op2,
    input  logic [W-1:0] alu_res,
    input  logic         alu_carry,
    input  logic         alu_z,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_last;
    logic           r_owner;
    logic [3:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;

    logic           w_gnt_any;
    logic           w_gnt;
    logic           w_accept;
    logic           w_rsp_done;

    // Grant looks only at valids and the last winner; ties go to the other side.
    assign w_gnt_any  = req0_valid | req1_valid;
    assign w_gnt      = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_accept   = (r_state == IDLE) & w_gnt_any;
    assign w_rsp_done = (r_state == RESP) & (r_owner ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        alu_EX      = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy       = 1'b0;
                req0_ready = w_gnt_any & ~w_gnt;
                req1_ready = w_gnt_any & w_gnt;
                if (w_accept) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                alu_EX      = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = ~r_owner;
                rsp1_valid = r_owner;
                if (w_rsp_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Holding registers keep driving the ALU after issue so its inputs stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else if (w_accept) begin
            r_last  <= w_gnt;
            r_owner <= w_gnt;
            r_op    <= w_gnt ? req1_op : req0_op;
            r_a     <= w_gnt ? req1_a  : req0_a;
            r_b     <= w_gnt ? req1_b  : req0_b;
        end
    end

    assign alu_I     = r_op;
    assign alu_op1   = r_a;
    assign alu_op2   = r_b;
    assign rsp_res   = alu_res;
    assign rsp_carry = alu_carry;
    assign rsp_z     = alu_z;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - vector table, scoreboard and corner sequences for alu_arbiter
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_res;
    logic        rsp_carry, rsp_z;
    logic [3:0]  alu_I;
    logic        alu_EX;
    logic [31:0] alu_op1, alu_op2;
    logic [31:0] alu_res = '0;
    logic        alu_carry = 1'b0;
    logic        alu_z = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_res(rsp_res), .rsp_carry(rsp_carry), .rsp_z(rsp_z),
        .alu_I(alu_I), .alu_EX(alu_EX), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_res(alu_res), .alu_carry(alu_carry), .alu_z(alu_z),
        .busy(busy)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
    } alu_out_t;

    // 1 ADD 2 SUB 3 AND 4 OR 5 XOR 6 SLT 7 SLTU 8 SLL 9 SRL 10 SRA 11 NOR 12 PASSA 13 PASSB
    function automatic alu_out_t alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        alu_out_t    o;
        logic [32:0] t;
        t = '0;
        case (op)
            4'd1:    t = {1'b0, a} + {1'b0, b};
            4'd2:    t = {1'b0, a} - {1'b0, b};
            4'd3:    t = {1'b0, a & b};
            4'd4:    t = {1'b0, a | b};
            4'd5:    t = {1'b0, a ^ b};
            4'd6:    t = ($signed(a) < $signed(b)) ? 33'd1 : 33'd0;
            4'd7:    t = (a < b) ? 33'd1 : 33'd0;
            4'd8:    t = {1'b0, a << b[4:0]};
            4'd9:    t = {1'b0, a >> b[4:0]};
            4'd10:   t = {1'b0, 32'($signed(a) >>> b[4:0])};
            4'd11:   t = {1'b0, ~(a | b)};
            4'd12:   t = {1'b0, a};
            4'd13:   t = {1'b0, b};
            default: t = '0;
        endcase
        o.res = t[31:0];
        o.c   = t[32];
        o.z   = (t[31:0] == 32'd0);
        return o;
    endfunction

    alu_out_t w_alu;
    assign w_alu = alu_f(alu_I, alu_op1, alu_op2);

    always @(posedge clk) begin
        if (alu_EX) begin
            alu_res   <= w_alu.res;
            alu_carry <= w_alu.c;
            alu_z     <= w_alu.z;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic     k;
        alu_out_t exp;
        int       t_acc;
        logic     seen;
    } sb_t;

    sb_t sb[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: push on request handshake, pop on response handshake.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
            end else begin
                if (rsp0_valid || rsp1_valid) begin
                    chk("rsp_both", 64'(rsp0_valid & rsp1_valid), 64'd0);
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        chk("rsp_route", 64'(rsp1_valid), 64'(sb[0].k));
                        if (!sb[0].seen) begin
                            chk("rsp_latency", 64'(cyc - sb[0].t_acc), 64'd2);
                            sb[0].seen = 1'b1;
                        end
                        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                            chk("sb_res", 64'(rsp_res), 64'(sb[0].exp.res));
                            chk("sb_carry", 64'(rsp_carry), 64'(sb[0].exp.c));
                            chk("sb_z", 64'(rsp_z), 64'(sb[0].exp.z));
                            void'(sb.pop_front());
                        end
                    end
                end
                if (req0_valid && req0_ready) begin
                    e.k = 1'b0; e.exp = alu_f(req0_op, req0_a, req0_b);
                    e.t_acc = cyc; e.seen = 1'b0;
                    sb.push_back(e);
                end
                if (req1_valid && req1_ready) begin
                    e.k = 1'b1; e.exp = alu_f(req1_op, req1_a, req1_b);
                    e.t_acc = cyc; e.seen = 1'b0;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic set_req(input logic k, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (k) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic wait_accept(input logic k);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (k ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (k) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) chk("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic k, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output logic c, output logic z, output int ex_n);
        logic got;
        got = 1'b0; res = '0; c = 1'b0; z = 1'b0; ex_n = 0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(k, 1'b1, op, a, b);
        wait_accept(k);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (alu_EX) begin
                ex_n++;
                chk("issue_op", 64'(alu_I), 64'(op));
            end
            if (k ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready)) begin
                res = rsp_res; c = rsp_carry; z = rsp_z;
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("rsp_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        k;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] r;
        logic        c, z, gr;
        int          ex_n, n;

        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        c, z, gr;
        int          ex_n, n;

        vecs[0] = '{1'b0, 4'd1,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b1};
        vecs[1] = '{1'b1, 4'd6,  32'd3,         32'd5,         32'd1,         1'b0, 1'b0};
        vecs[2] = '{1'b0, 4'd6,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'd7,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b1};
        vecs[4] = '{1'b0, 4'd2,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'd15, 32'd7,         32'd9,         32'd0,         1'b0, 1'b1};
        vecs[6] = '{1'b0, 4'd0,  32'd3,         32'd3,         32'd0,         1'b0, 1'b1};
        vecs[7] = '{1'b1, 4'd10, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 4'd5,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0,         1'b0, 1'b1};
        vecs[9] = '{1'b1, 4'd13, 32'd0,         32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};

        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ex", 64'(alu_EX), 64'd0);
        chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("rst_hold_op", 64'({alu_I, alu_op1, alu_op2}), 64'd0);

        // Tie from reset: strict alternation starting with req0.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(1'b0, 1'b1, 4'd1, 32'd100, 32'd23);
        set_req(1'b1, 1'b1, 4'd2, 32'd100, 32'd23);
        @(negedge clk);
        chk("first_cycle_req0_ready", 64'(req0_ready), 64'd1);
        chk("first_cycle_req1_ready", 64'(req1_ready), 64'd0);
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (req0_valid && req0_ready) begin
                gr = 1'b0;
            end else if (req1_valid && req1_ready) begin
                gr = 1'b1;
            end else begin
                continue;
            end
            chk("tie_grant", 64'(gr), 64'(n % 2));
            n++;
        end
        chk("tie_count", 64'(n), 64'd4);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].b, r, c, z, ex_n);
            chk($sformatf("vec%0d_res", i), 64'(r), 64'(vecs[i].res));
            chk($sformatf("vec%0d_carry", i), 64'(c), 64'(vecs[i].c));
            chk($sformatf("vec%0d_z", i), 64'(z), 64'(vecs[i].z));
            chk($sformatf("vec%0d_ex_pulses", i), 64'(ex_n), 64'd1);
            chk($sformatf("vec%0d_idle", i), 64'(busy), 64'd0);
        end

        // Backpressure on req1 while req0 waits.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b0;
        set_req(1'b1, 1'b1, 4'd6, 32'd3, 32'd5);
        wait_accept(1'b1);
        set_req(1'b0, 1'b1, 4'd1, 32'd2, 32'd3);
        @(negedge clk);
        chk("bp_issue_req0_ready", 64'(req0_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_rsp1_valid", 64'(rsp1_valid), 64'd1);
            chk("bp_rsp0_valid", 64'(rsp0_valid), 64'd0);
            chk("bp_res", 64'(rsp_res), 64'd1);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_req0_ready", 64'(req0_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(rsp1_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_after_busy", 64'(busy), 64'd0);
        chk("bp_after_req0_ready", 64'(req0_ready), 64'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_idle();

        // Ready on the wrong response channel must not complete req0.
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        set_req(1'b0, 1'b1, 4'd4, 32'h0000_00F0, 32'h0000_000F);
        wait_accept(1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("mis_rsp0_valid", 64'(rsp0_valid), 64'd1);
            chk("mis_rsp1_valid", 64'(rsp1_valid), 64'd0);
            chk("mis_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp0_ready = 1'b1;
        wait_idle();

        // Reset during ISSUE drops the op.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(1'b0, 1'b1, 4'd1, 32'd1, 32'd1);
        wait_accept(1'b0);
        @(negedge clk);
        chk("mid_issue_ex", 64'(alu_EX), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ex", 64'(alu_EX), 64'd0);
        chk("mid_rst_valids", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 64'({rsp0_valid, rsp1_valid, busy}), 64'd0);
        end
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b1, 4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0);
        set_req(1'b1, 1'b1, 4'd11, 32'd0, 32'd0);
        @(negedge clk);
        chk("post_rst_req0_ready", 64'(req0_ready), 64'd1);
        chk("post_rst_req1_ready", 64'(req1_ready), 64'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
